// File: rtl/mc_pkg.sv
// mc_pkg: state codes, opcode/funct constants and datapath select encodings for the multi-cycle control unit
package mc_pkg;
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;
    localparam logic [1:0] PC_ALU = 2'b00;
    localparam logic [1:0] PC_OUT = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction/status inputs and datapath strobes between control unit and datapath
interface multicycle_control_if #(
    parameter int OP_W = 6,
    parameter int FUNCT_W = 6,
    parameter int ALUCTR_W = 3
);
    logic [OP_W-1:0] op;
    logic [FUNCT_W-1:0] funct;
    logic zero, mem_ready;
    logic pc_wr, ir_wr, mem_rd, mem_wr, iord, regdst, regwr, memtoreg, alusrca, extop, illegal, instr_done;
    logic [1:0] alusrcb, pcsrc;
    logic [ALUCTR_W-1:0] aluctr;
    logic [3:0] state;
    modport master (
        input op, funct, zero, mem_ready,
        output pc_wr, ir_wr, mem_rd, mem_wr, iord, regdst, regwr, memtoreg, alusrca, alusrcb,
        output pcsrc, extop, aluctr, illegal, instr_done, state
    );
    modport slave (
        output op, funct, zero, mem_ready,
        input pc_wr, ir_wr, mem_rd, mem_wr, iord, regdst, regwr, memtoreg, alusrca, alusrcb,
        input pcsrc, extop, aluctr, illegal, instr_done, state
    );
endinterface

// File: rtl/multicycle_control_alu_decode.sv
// alu_decode: per-state ALU operation select and R-type funct legality
module alu_decode
    import mc_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int FUNCT_W = 6,
    parameter int ALUCTR_W = 3
) (
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT_W-1:0]  funct,
    input  state_t              state,
    output logic [ALUCTR_W-1:0] aluctr,
    output logic                funct_ok
);
    logic [2:0] fcode;
    always_comb begin
        funct_ok = 1'b1;
        fcode = ALU_ADD;
        case (funct)
            F_ADD: fcode = ALU_ADD;
            F_SUB: fcode = ALU_SUB;
            F_AND: fcode = ALU_AND;
            F_OR:  fcode = ALU_OR;
            F_SLT: fcode = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end
    assign aluctr = ALUCTR_W'(state == S_EXEC ? fcode :
                              state == S_BRANCH ? ALU_SUB :
                              (state == S_IEXEC && op == OP_ORI) ? ALU_OR : ALU_ADD);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM driving datapath strobes per state
module multicycle_control
    import mc_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int FUNCT_W = 6,
    parameter int ALUCTR_W = 3,
    parameter bit WAIT_MEM = 1'b1
) (
    input logic clk,
    input logic rst,
    multicycle_control_if.master bus
);
    state_t st, nx;
    logic lw_q, rdy, legal, funct_ok;
    logic [ALUCTR_W-1:0] alu;
    alu_decode #(.OP_W(OP_W), .FUNCT_W(FUNCT_W), .ALUCTR_W(ALUCTR_W)) u_alu (
        .op(bus.op), .funct(bus.funct), .state(st), .aluctr(alu), .funct_ok(funct_ok)
    );
    assign rdy = bus.mem_ready | !WAIT_MEM;
    assign legal = bus.op == OP_R ? funct_ok : bus.op inside {OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI};
    always_comb begin
        nx = S_FETCH;
        case (st)
            S_FETCH:  nx = rdy ? S_DECODE : S_FETCH;
            S_DECODE: nx = !legal ? S_FETCH :
                           bus.op == OP_R ? S_EXEC :
                           (bus.op == OP_LW || bus.op == OP_SW) ? S_MEMADR :
                           bus.op == OP_BEQ ? S_BRANCH :
                           bus.op == OP_J ? S_JUMP : S_IEXEC;
            S_MEMADR: nx = lw_q ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nx = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nx = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   nx = S_RWB;
            S_IEXEC:  nx = S_IWB;
            default:  nx = S_FETCH;
        endcase
    end
    // lw/sw is latched in DECODE so MEMADR does not depend on op
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= S_FETCH;
            lw_q <= 1'b0;
        end else begin
            st <= nx;
            if (st == S_DECODE) lw_q <= bus.op == OP_LW;
        end
    end
    always_comb begin
        bus.pc_wr = 1'b0;
        bus.ir_wr = 1'b0;
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        bus.iord = 1'b0;
        bus.regdst = 1'b0;
        bus.regwr = 1'b0;
        bus.memtoreg = 1'b0;
        bus.alusrca = 1'b0;
        bus.alusrcb = SRCB_B;
        bus.pcsrc = PC_ALU;
        bus.extop = 1'b0;
        bus.illegal = 1'b0;
        bus.instr_done = 1'b0;
        if (rst) begin
            case (st)
                S_FETCH: begin
                    bus.mem_rd = 1'b1;
                    bus.alusrcb = SRCB_4;
                    bus.pc_wr = rdy;
                    bus.ir_wr = rdy;
                end
                S_DECODE: begin
                    bus.alusrcb = SRCB_IMM2;
                    bus.extop = 1'b1;
                    bus.illegal = !legal;
                end
                S_MEMADR: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = SRCB_IMM;
                    bus.extop = 1'b1;
                end
                S_MEMRD: begin
                    bus.mem_rd = 1'b1;
                    bus.iord = 1'b1;
                end
                S_MEMWB: begin
                    bus.regwr = 1'b1;
                    bus.memtoreg = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_wr = 1'b1;
                    bus.iord = 1'b1;
                    bus.instr_done = rdy;
                end
                S_EXEC: bus.alusrca = 1'b1;
                S_RWB: begin
                    bus.regwr = 1'b1;
                    bus.regdst = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    bus.alusrca = 1'b1;
                    bus.pcsrc = PC_OUT;
                    bus.pc_wr = bus.zero;
                    bus.instr_done = 1'b1;
                end
                S_JUMP: begin
                    bus.pcsrc = PC_JMP;
                    bus.pc_wr = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_IEXEC: begin
                    bus.alusrca = 1'b1;
                    bus.alusrcb = SRCB_IMM;
                    bus.extop = bus.op != OP_ORI;
                end
                S_IWB: begin
                    bus.regwr = 1'b1;
                    bus.instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end
    assign bus.aluctr = rst ? alu : '0;
    assign bus.state = rst ? st : 4'd0;
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Parametrised multi-cycle successor to the single-cycle control unit. It sequences each MIPS instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. Per state it drives the datapath strobes, including PC/IR write enables and the ALU operand selects. It sits between the instruction register (op, funct), the ALU zero flag and the unified memory ready handshake, and replaces the single-cycle control plus ALU-control pair in the multi-cycle CPU top.

Parameters:
OP_W, 6, opcode field width
FUNCT_W, 6, function field width
ALUCTR_W, 3, ALU control code width
WAIT_MEM, 1, 1 = FETCH/MEMRD/MEMWR hold until mem_ready; 0 = mem_ready ignored, treated as 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
op  in  OP_W  IR[31:26]
funct  in  FUNCT_W  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
pc_wr  out  1  PC write enable
ir_wr  out  1  IR write enable
mem_rd  out  1  memory read
mem_wr  out  1  memory write
iord  out  1  0 = address from PC, 1 = from ALUOut
regdst  out  1  1 = rd, 0 = rt
regwr  out  1  register file write
memtoreg  out  1  1 = MDR to register file, 0 = ALUOut
alusrca  out  1  0 = PC, 1 = busA
alusrcb  out  2  00 busB, 01 const 4, 10 ext imm, 11 ext imm<<2
pcsrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
extop  out  1  1 = sign-extend, 0 = zero-extend
aluctr  out  ALUCTR_W  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
illegal  out  1  one-cycle pulse, undecodable instruction
instr_done  out  1  one-cycle pulse in the final state of each instruction
state  out  4  current state code, for debug/verification

Behaviour:
- Reset (rst low, async): state <= FETCH. While rst is low, every output is forced to 0 (state = 0). First FETCH strobes appear in the cycle after rst rises.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11. Codes 12–15 are unreachable and recover to FETCH next cycle with all outputs 0.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, ori 001101.
- R-type functs: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- Outputs not listed for a state are 0.

State actions and transitions:
- FETCH: mem_rd=1, iord=0, alusrca=0, alusrcb=01, aluctr=ADD, pcsrc=00. pc_wr=ir_wr=rdy, where rdy = mem_ready or WAIT_MEM==0. Goes to DECODE when rdy, else stays in FETCH.
- DECODE: alusrca=0, alusrcb=11, extop=1, aluctr=ADD (precomputes the branch target).
  - Next state: R -> EXEC; lw/sw -> MEMADR; beq -> BRANCH; j -> JUMP; addi/ori -> IEXEC.
  - Unknown op, or R-type with unknown funct: illegal=1 this cycle, go to FETCH; no register or memory write occurs.
- MEMADR: alusrca=1, alusrcb=10, extop=1, ADD. lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_rd=1, iord=1. Goes to MEMWB when rdy, else holds.
- MEMWB: regwr=1, regdst=0, memtoreg=1, instr_done=1. Goes to FETCH.
- MEMWR: mem_wr=1, iord=1. On rdy: instr_done=1, go to FETCH; else hold. mem_wr stays high for the whole hold.
- EXEC: alusrca=1, alusrcb=00, aluctr from funct. Goes to RWB.
- RWB: regwr=1, regdst=1, memtoreg=0, instr_done=1. Goes to FETCH.
- BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01, pc_wr=zero (Mealy), instr_done=1. Goes to FETCH.
- JUMP: pcsrc=10, pc_wr=1, instr_done=1. Goes to FETCH.
- IEXEC: alusrca=1, alusrcb=10. addi: extop=1, ADD. ori: extop=0, OR. Goes to IWB.
- IWB: regwr=1, regdst=0, memtoreg=0, instr_done=1. Goes to FETCH.

Latency and timing rules:
- With rdy=1, cycles per instruction: lw 5, sw 4, R 4, addi/ori 4, beq 3, j 3. Each wait cycle adds 1.
- op/funct are sampled only in DECODE, EXEC and IEXEC; the IR is stable in those states. No other inputs are registered.
- Reset mid-wait (e.g. in MEMWR): outputs drop to 0 immediately and the state returns to FETCH; no partial write is re-issued.

Decomposition:
- Package mc_pkg holds:
  - state code localparams
  - opcode and funct constants
  - aluctr codes
  - alusrcb and pcsrc encodings
- Sub-module alu_decode (combinational): op/funct/state -> aluctr plus funct-legal flag. It is instantiated once; the FSM and output decode remain in multicycle_control.

Test Plan:
- Reset release, mem_ready=1, op=100011 -> states 0,1,2,3,4,0. regwr=1 and memtoreg=1 only in state 4; instr_done pulses once.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_wr=1, iord=1 for 4 consecutive cycles; instr_done on the 4th; no regwr.
- beq with zero=1 -> pc_wr=1 and pcsrc=01 in state 8. Repeat with zero=0 -> pc_wr=0. Both take 3 cycles.
- R-type funct=101010 -> aluctr=100 in EXEC. funct=000111 -> illegal pulse in DECODE, back to FETCH, no regwr.
- ori -> extop=0 and aluctr=011 in IEXEC. addi -> extop=1 and aluctr=000. IWB has regdst=0.
- WAIT_MEM=0 with mem_ready tied 0 -> lw still completes in 5 cycles.
- Assert rst mid-MEMRD -> all outputs 0 asynchronously; FETCH begins one cycle after rst deasserts.
